mem_stage_unit: RTL and testbench

- Memory (MEM) stage of the MIPS multicycle pipeline.
- Consumes the EX/MEM pipeline register outputs: control bits, PC, ALU result, store value and destination.
- Drives a data memory with a req/ready handshake that may take several cycles. Raises freeze to stall upstream stages while an access is outstanding.
- Registers the MEM/WB pipeline fields for the write-back stage.

---
 rtl/mips_pkg.sv | 24 ++
 rtl/mem_wb_reg.sv | 33 +++
 rtl/mem_stage_unit.sv | 130 +++++++++++++
 tb/tb_mem_stage_unit.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: widths, data-memory base address, MEM-stage
// FSM encoding and the MEM/WB payload layout.
package mips_pkg;

   localparam int unsigned DATA_W     = 32;
   localparam int unsigned REG_ADDR_W = 5;

   localparam logic [DATA_W-1:0] BASE_ADDR_DEF = 32'd1024;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_e;

   typedef struct packed {
      logic                  wb_en;
      logic                  mem_r_en;
      logic [DATA_W-1:0]     pc;
      logic [DATA_W-1:0]     alu_result;
      logic [DATA_W-1:0]     read_value;
      logic [REG_ADDR_W-1:0] dest;
   } mem_wb_t;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: loads a full payload, or inserts a bubble by
// clearing the control bits while the data fields hold.
module mem_wb_reg
   import mips_pkg::*;
(
   input  logic    clk,
   input  logic    rst,
   input  logic    load,
   input  logic    bubble,
   input  mem_wb_t data_in,
   output mem_wb_t data_out
);

   mem_wb_t wb_d, wb_q;

   always_comb begin
      wb_d = wb_q;
      if (load) begin
         wb_d = data_in;
      end else if (bubble) begin
         wb_d.wb_en    = 1'b0;
         wb_d.mem_r_en = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) wb_q <= '0;
      else     wb_q <= wb_d;
   end

   assign data_out = wb_q;

endmodule

// File: rtl/mem_stage_unit.sv
// MIPS MEM stage: drives the data memory over a req/ready handshake, stalls
// upstream with freeze while an access is outstanding, and feeds MEM/WB.
module mem_stage_unit
   import mips_pkg::*;
#(
   parameter int unsigned       ADDR_W    = 10,
   parameter logic [DATA_W-1:0] BASE_ADDR = BASE_ADDR_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  WB_en_in,
   input  logic                  MEM_R_EN_in,
   input  logic                  MEM_W_EN_in,
   input  logic [DATA_W-1:0]     PC_in,
   input  logic [DATA_W-1:0]     ALU_result_in,
   input  logic [DATA_W-1:0]     ST_val_in,
   input  logic [REG_ADDR_W-1:0] Dest_in,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [DATA_W-1:0]     mem_wdata,
   input  logic [DATA_W-1:0]     mem_rdata,
   input  logic                  mem_ready,
   output logic                  freeze,
   output logic                  WB_en,
   output logic                  MEM_R_EN,
   output logic [DATA_W-1:0]     PC,
   output logic [DATA_W-1:0]     ALU_result,
   output logic [DATA_W-1:0]     Mem_read_value,
   output logic [REG_ADDR_W-1:0] Dest
);

   state_e              state_d, state_q;
   logic                mem_req_d, mem_req_q;
   logic                mem_we_d, mem_we_q;
   logic [ADDR_W-1:0]   mem_addr_d, mem_addr_q;
   logic [DATA_W-1:0]   mem_wdata_d, mem_wdata_q;
   logic                mem_op, is_load;
   logic                freeze_c;
   logic                wb_load, wb_bubble;
   mem_wb_t             wb_in, wb_out;

   // A simultaneous read+write request is treated as a store.
   assign mem_op  = MEM_R_EN_in | MEM_W_EN_in;
   assign is_load = MEM_R_EN_in & ~MEM_W_EN_in;

   always_comb begin
      state_d          = state_q;
      mem_req_d        = mem_req_q;
      mem_we_d         = mem_we_q;
      mem_addr_d       = mem_addr_q;
      mem_wdata_d      = mem_wdata_q;
      freeze_c         = 1'b0;
      wb_load          = 1'b0;
      wb_bubble        = 1'b0;
      wb_in.wb_en      = WB_en_in;
      wb_in.mem_r_en   = MEM_R_EN_in;
      wb_in.pc         = PC_in;
      wb_in.alu_result = ALU_result_in;
      wb_in.read_value = '0;
      wb_in.dest       = Dest_in;

      case (state_q)
         ST_IDLE: begin
            if (mem_op) begin
               freeze_c    = 1'b1;
               wb_bubble   = 1'b1;
               state_d     = ST_WAIT;
               mem_req_d   = 1'b1;
               mem_we_d    = MEM_W_EN_in;
               mem_addr_d  = ADDR_W'((ALU_result_in - BASE_ADDR) >> 2);
               mem_wdata_d = ST_val_in;
            end else begin
               wb_load = 1'b1;
            end
         end
         ST_WAIT: begin
            if (mem_ready) begin
               wb_load   = 1'b1;
               state_d   = ST_IDLE;
               mem_req_d = 1'b0;
               if (is_load) wb_in.read_value = mem_rdata;
            end else begin
               freeze_c  = 1'b1;
               wb_bubble = 1'b1;
            end
         end
      endcase

      if (rst) freeze_c = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   mem_wb_reg u_mem_wb_reg (
      .clk      (clk),
      .rst      (rst),
      .load     (wb_load),
      .bubble   (wb_bubble),
      .data_in  (wb_in),
      .data_out (wb_out)
   );

   assign mem_req        = mem_req_q;
   assign mem_we         = mem_we_q;
   assign mem_addr       = mem_addr_q;
   assign mem_wdata      = mem_wdata_q;
   assign freeze         = freeze_c;
   assign WB_en          = wb_out.wb_en;
   assign MEM_R_EN       = wb_out.mem_r_en;
   assign PC             = wb_out.pc;
   assign ALU_result     = wb_out.alu_result;
   assign Mem_read_value = wb_out.read_value;
   assign Dest           = wb_out.dest;

endmodule

// File: tb/tb_mem_stage_unit.sv
// Directed bench for mem_stage_unit: nop, load, store, back-to-back ops,
// reset during an access, and a simultaneous read+write request.
module tb_mem_stage_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        WB_en_in, MEM_R_EN_in, MEM_W_EN_in;
   logic [31:0] PC_in, ALU_result_in, ST_val_in;
   logic [4:0]  Dest_in;
   logic        mem_req, mem_we;
   logic [9:0]  mem_addr;
   logic [31:0] mem_wdata, mem_rdata;
   logic        mem_ready, freeze;
   logic        WB_en, MEM_R_EN;
   logic [31:0] PC, ALU_result, Mem_read_value;
   logic [4:0]  Dest;

   int n_tests = 0;
   int n_fail  = 0;

   mem_stage_unit dut (
      .clk(clk), .rst(rst),
      .WB_en_in(WB_en_in), .MEM_R_EN_in(MEM_R_EN_in), .MEM_W_EN_in(MEM_W_EN_in),
      .PC_in(PC_in), .ALU_result_in(ALU_result_in), .ST_val_in(ST_val_in), .Dest_in(Dest_in),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready), .freeze(freeze),
      .WB_en(WB_en), .MEM_R_EN(MEM_R_EN), .PC(PC), .ALU_result(ALU_result),
      .Mem_read_value(Mem_read_value), .Dest(Dest)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Registered outputs are checked 1 time unit after the edge; inputs follow.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic wb, input logic r, input logic w, input logic [31:0] pc,
                        input logic [31:0] alu, input logic [31:0] st, input logic [4:0] dst);
      WB_en_in = wb; MEM_R_EN_in = r; MEM_W_EN_in = w;
      PC_in = pc; ALU_result_in = alu; ST_val_in = st; Dest_in = dst;
   endtask

   task automatic chk_freeze(input string tag, input logic exp);
      #1;
      chk(tag, 32'(freeze), 32'(exp));
   endtask

   initial begin
      rst = 1'b1; mem_ready = 1'b0; mem_rdata = '0;
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
      tick(); tick();

      // Reset state
      chk("rst_mem_req",   32'(mem_req), 32'd0);
      chk("rst_mem_we",    32'(mem_we), 32'd0);
      chk("rst_mem_addr",  32'(mem_addr), 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_wb_en",     32'(WB_en), 32'd0);
      chk("rst_pc",        PC, 32'd0);
      chk("rst_rdval",     Mem_read_value, 32'd0);
      chk_freeze("rst_freeze", 1'b0);
      rst = 1'b0;

      // Non-memory op
      drive(1'b1, 1'b0, 1'b0, 32'h40, 32'h7, 32'h0, 5'd3);
      chk_freeze("nop_freeze", 1'b0);
      tick();
      chk("nop_wb_en",   32'(WB_en), 32'd1);
      chk("nop_alu",     ALU_result, 32'd7);
      chk("nop_dest",    32'(Dest), 32'd3);
      chk("nop_pc",      PC, 32'h40);
      chk("nop_rdval",   Mem_read_value, 32'd0);
      chk("nop_mem_req", 32'(mem_req), 32'd0);

      // Load from 1032, two wait cycles
      drive(1'b1, 1'b1, 1'b0, 32'h44, 32'd1032, 32'h0, 5'd8);
      chk_freeze("ld_freeze_req", 1'b1);
      tick();
      chk("ld_mem_req",  32'(mem_req), 32'd1);
      chk("ld_mem_addr", 32'(mem_addr), 32'd2);
      chk("ld_mem_we",   32'(mem_we), 32'd0);
      chk("ld_bubble0",  32'(WB_en), 32'd0);
      chk_freeze("ld_freeze_w1", 1'b1);
      tick();
      chk("ld_bubble1",  32'(WB_en), 32'd0);
      chk_freeze("ld_freeze_w2", 1'b1);
      tick();
      chk("ld_bubble2",  32'(WB_en), 32'd0);
      chk("ld_req_held", 32'(mem_req), 32'd1);
      mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      chk_freeze("ld_freeze_rdy", 1'b0);
      tick();
      mem_ready = 1'b0; mem_rdata = '0;
      chk("ld_rdval",    Mem_read_value, 32'hDEAD_BEEF);
      chk("ld_mem_r_en", 32'(MEM_R_EN), 32'd1);
      chk("ld_wb_en",    32'(WB_en), 32'd1);
      chk("ld_dest",     32'(Dest), 32'd8);
      chk("ld_req_done", 32'(mem_req), 32'd0);

      // Store to 1024, one wait cycle: freeze high exactly two cycles
      drive(1'b0, 1'b0, 1'b1, 32'h48, 32'd1024, 32'h1234_5678, 5'd0);
      chk_freeze("st_freeze_req", 1'b1);
      tick();
      chk("st_mem_req",   32'(mem_req), 32'd1);
      chk("st_mem_we",    32'(mem_we), 32'd1);
      chk("st_mem_addr",  32'(mem_addr), 32'd0);
      chk("st_mem_wdata", mem_wdata, 32'h1234_5678);
      chk_freeze("st_freeze_w1", 1'b1);
      tick();
      mem_ready = 1'b1; mem_rdata = 32'hFFFF_0000;
      chk_freeze("st_freeze_rdy", 1'b0);
      tick();
      mem_ready = 1'b0; mem_rdata = '0;
      chk("st_rdval",    Mem_read_value, 32'd0);
      chk("st_pc",       PC, 32'h48);
      chk("st_mem_r_en", 32'(MEM_R_EN), 32'd0);
      chk("st_req_done", 32'(mem_req), 32'd0);

      // Back-to-back load (1040) then store (1048), one wait cycle each
      drive(1'b1, 1'b1, 1'b0, 32'h4C, 32'd1040, 32'h0, 5'd9);
      chk_freeze("bb_ld_freeze", 1'b1);
      tick();
      chk("bb_ld_addr", 32'(mem_addr), 32'd4);
      chk("bb_ld_we",   32'(mem_we), 32'd0);
      tick();
      mem_ready = 1'b1; mem_rdata = 32'hCAFE_0001;
      tick();
      mem_ready = 1'b0; mem_rdata = '0;
      chk("bb_ld_wb_en", 32'(WB_en), 32'd1);
      chk("bb_ld_rdval", Mem_read_value, 32'hCAFE_0001);
      chk("bb_ld_dest",  32'(Dest), 32'd9);
      chk("bb_ld_req0",  32'(mem_req), 32'd0);
      drive(1'b0, 1'b0, 1'b1, 32'h50, 32'd1048, 32'hAAAA_5555, 5'd0);
      chk_freeze("bb_st_freeze", 1'b1);
      tick();
      chk("bb_st_req",   32'(mem_req), 32'd1);
      chk("bb_st_addr",  32'(mem_addr), 32'd6);
      chk("bb_st_wdata", mem_wdata, 32'hAAAA_5555);
      chk("bb_no_dup",   32'(WB_en), 32'd0);
      tick();
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      chk("bb_st_pc",     PC, 32'h50);
      chk("bb_st_rdval",  Mem_read_value, 32'd0);
      chk("bb_st_req0",   32'(mem_req), 32'd0);

      // Reset while waiting, then a stray ready
      drive(1'b1, 1'b1, 1'b0, 32'h54, 32'd1100, 32'h0, 5'd4);
      tick();
      chk("rw_req",  32'(mem_req), 32'd1);
      chk("rw_addr", 32'(mem_addr), 32'd19);
      rst = 1'b1;
      chk_freeze("rw_freeze_in_rst", 1'b0);
      tick();
      chk("rw_req_drop", 32'(mem_req), 32'd0);
      chk("rw_addr0",    32'(mem_addr), 32'd0);
      chk("rw_pc0",      PC, 32'd0);
      rst = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
      mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
      chk_freeze("rw_stray_freeze", 1'b0);
      tick();
      mem_ready = 1'b0; mem_rdata = '0;
      chk("rw_stray_wb_en", 32'(WB_en), 32'd0);
      chk("rw_stray_rdval", Mem_read_value, 32'd0);
      chk("rw_stray_req",   32'(mem_req), 32'd0);

      // Read and write together: write wins, no load data
      drive(1'b1, 1'b1, 1'b1, 32'h58, 32'd1028, 32'h0000_0BAD, 5'd5);
      chk_freeze("rwboth_freeze", 1'b1);
      tick();
      chk("rwboth_we",   32'(mem_we), 32'd1);
      chk("rwboth_addr", 32'(mem_addr), 32'd1);
      mem_ready = 1'b1; mem_rdata = 32'h5555_5555;
      chk_freeze("rwboth_freeze_rdy", 1'b0);
      tick();
      mem_ready = 1'b0; mem_rdata = '0;
      chk("rwboth_rdval", Mem_read_value, 32'd0);
      chk("rwboth_dest",  32'(Dest), 32'd5);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
